handshake_fifo_buffer: RTL and testbench

//  Elastic FIFO stage on a valid/ready dataflow channel, placed directly downstream of constant and

---
 rtl/handshake_fifo_buffer.sv | 111 +++++++++++
 tb/tb_handshake_fifo_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_fifo_buffer.sv
// Elastic valid/ready FIFO stage holding up to DEPTH tokens in order; latency 1 cycle (0 with
// HANDSHAKE_FIFO_BYPASS_EN when empty); ins_ready depends only on occupancy, never on outs_ready.
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        ins,
  input  logic                         ins_valid,
  output logic                         ins_ready,
  output logic [DATA_WIDTH-1:0]        outs,
  output logic                         outs_valid,
  input  logic                         outs_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  occ_e                  occ;
  logic                  head_vld;
  logic [DATA_WIDTH-1:0] head_dat;
  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  rd_adv;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    occ = OCC_PARTIAL;
    if (count_q == '0) begin
      occ = OCC_EMPTY;
    end else if (count_q == CNT_W'(DEPTH)) begin
      occ = OCC_FULL;
    end
  end

  assign ins_ready = (occ != OCC_FULL);
  assign head_vld  = (occ != OCC_EMPTY);
  assign head_dat  = head_vld ? mem_q[rd_ptr_q] : '0;
  assign push      = ins_valid & ins_ready;
  assign pop       = outs_valid & outs_ready;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
  logic bypass;
  // When empty the producer drives the consumer directly; storage only happens on a stall.
  assign bypass     = (occ == OCC_EMPTY);
  assign outs_valid = head_vld | (bypass & ins_valid);
  assign outs       = bypass ? (ins_valid ? ins : '0) : head_dat;
  assign wr_en      = push & ~(bypass & outs_ready);
  assign rd_adv     = pop & head_vld;
`else
  assign outs_valid = head_vld;
  assign outs       = head_dat;
  assign wr_en      = push;
  assign rd_adv     = pop;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (rd_adv) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({wr_en, rd_adv})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: outs is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= ins;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Directed tests on a DEPTH=4 buffer plus a randomized scoreboard run on a DEPTH=3 buffer.
module tb_handshake_fifo_buffer;

  localparam int DW = 19;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] ins, outs;
  logic          ins_valid, ins_ready, outs_valid, outs_ready;
  logic [2:0]    count;

  logic [DW-1:0] s_ins, s_outs;
  logic          s_ins_valid, s_ins_ready, s_outs_valid, s_outs_ready;
  logic [1:0]    s_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  handshake_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst),
    .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready),
    .count(count)
  );

  handshake_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst),
    .ins(s_ins), .ins_valid(s_ins_valid), .ins_ready(s_ins_ready),
    .outs(s_outs), .outs_valid(s_outs_valid), .outs_ready(s_outs_ready),
    .count(s_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; ins = '0; ins_valid = 1'b0; outs_ready = 1'b0;
    s_ins = '0; s_ins_valid = 1'b0; s_outs_ready = 1'b0;
    #3;
    n_checks++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (outs_valid !== 1'b0) $display("FAIL reset_outs_valid got=%b exp=0", outs_valid); else n_pass++;
    n_checks++; if (ins_ready !== 1'b1) $display("FAIL reset_ins_ready got=%b exp=1", ins_ready); else n_pass++;
    n_checks++; if (outs !== '0) $display("FAIL reset_outs got=%h exp=0", outs); else n_pass++;
    tick; rst = 1'b1; tick;
    ins_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins = DW'(32'h100 + i);
      tick;
    end
    ins_valid = 1'b0;
    #1;
    n_checks++; if (count !== 3'd3) $display("FAIL prereset_count got=%0d exp=3", count); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) $display("FAIL midreset_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (outs_valid !== 1'b0) $display("FAIL midreset_outs_valid got=%b exp=0", outs_valid); else n_pass++;
    n_checks++; if (ins_ready !== 1'b1) $display("FAIL midreset_ins_ready got=%b exp=1", ins_ready); else n_pass++;
    n_checks++; if (outs !== '0) $display("FAIL midreset_outs got=%h exp=0", outs); else n_pass++;
    tick; rst = 1'b1; tick;
    n_checks++; if (count !== 3'd0) $display("FAIL postreset_count got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_single_token;
    ins = 19'h3EC22; ins_valid = 1'b1; outs_ready = 1'b1;
    #1;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    n_checks++; if (outs_valid !== 1'b1) $display("FAIL bypass_valid got=%b exp=1", outs_valid); else n_pass++;
    n_checks++; if (outs !== 19'h3EC22) $display("FAIL bypass_outs got=%h exp=3ec22", outs); else n_pass++;
    tick; ins_valid = 1'b0; #1;
    n_checks++; if (count !== 3'd0) $display("FAIL bypass_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (outs_valid !== 1'b0) $display("FAIL bypass_after_valid got=%b exp=0", outs_valid); else n_pass++;
`else
    n_checks++; if (outs_valid !== 1'b0) $display("FAIL single_nocomb_valid got=%b exp=0", outs_valid); else n_pass++;
    tick; ins_valid = 1'b0; #1;
    n_checks++; if (count !== 3'd1) $display("FAIL single_count1 got=%0d exp=1", count); else n_pass++;
    n_checks++; if (outs_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", outs_valid); else n_pass++;
    n_checks++; if (outs !== 19'h3EC22) $display("FAIL single_outs got=%h exp=3ec22", outs); else n_pass++;
    tick;
    n_checks++; if (count !== 3'd0) $display("FAIL single_count0 got=%0d exp=0", count); else n_pass++;
    n_checks++; if (outs_valid !== 1'b0) $display("FAIL single_after_valid got=%b exp=0", outs_valid); else n_pass++;
`endif
    outs_ready = 1'b0;
  endtask

  task automatic test_fill_backpressure;
    logic p;
    outs_ready = 1'b0; ins_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      ins = DW'(k);
      tick;
    end
    n_checks++; if (count !== 3'd4) $display("FAIL fill_count got=%0d exp=4", count); else n_pass++;
    n_checks++; if (ins_ready !== 1'b0) $display("FAIL fill_ins_ready got=%b exp=0", ins_ready); else n_pass++;
    ins = DW'(5);
    tick;
    n_checks++; if (count !== 3'd4) $display("FAIL fill_hold_count got=%0d exp=4", count); else n_pass++;
    n_checks++; if (outs !== DW'(1)) $display("FAIL fill_hold_outs got=%h exp=1", outs); else n_pass++;
    outs_ready = 1'b1;
    #1;
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (outs_valid !== 1'b1 || outs !== DW'(k))
        $display("FAIL fill_order got=%b/%h exp=1/%h", outs_valid, outs, DW'(k));
      else n_pass++;
      p = ins_valid & ins_ready;
      tick;
      if (p) ins_valid = 1'b0;
      if (k == 1) begin
        n_checks++; if (ins_ready !== 1'b1) $display("FAIL fill_ready_return got=%b exp=1", ins_ready); else n_pass++;
        n_checks++; if (count !== 3'd3) $display("FAIL fill_after_pop_count got=%0d exp=3", count); else n_pass++;
      end
    end
    n_checks++; if (count !== 3'd0) $display("FAIL fill_drained_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (ins_valid !== 1'b0) $display("FAIL fill_fifth_accepted got=%b exp=0", ins_valid); else n_pass++;
    outs_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    outs_ready = 1'b0; ins_valid = 1'b1;
    ins = DW'(100); tick;
    ins = DW'(101); tick;
    n_checks++; if (count !== 3'd2) $display("FAIL b2b_prefill got=%0d exp=2", count); else n_pass++;
    outs_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ins = DW'(102 + i);
      #1;
      n_checks++;
      if (outs_valid !== 1'b1 || outs !== DW'(100 + i))
        $display("FAIL b2b_order got=%b/%h exp=1/%h", outs_valid, outs, DW'(100 + i));
      else n_pass++;
      tick;
      n_checks++; if (count !== 3'd2) $display("FAIL b2b_count got=%0d exp=2", count); else n_pass++;
    end
    ins_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (outs_valid !== 1'b1 || outs !== DW'(110 + i))
        $display("FAIL b2b_drain got=%b/%h exp=1/%h", outs_valid, outs, DW'(110 + i));
      else n_pass++;
      tick;
    end
    n_checks++; if (count !== 3'd0) $display("FAIL b2b_final_count got=%0d exp=0", count); else n_pass++;
    outs_ready = 1'b0;
  endtask

  task automatic test_random_depth3;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] prev_outs;
    logic          prev_stall;
    logic          holding;
    logic          push, pop;
    int            seq;
    prev_stall = 1'b0; holding = 1'b0; prev_outs = '0; seq = 1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (!holding) begin
        s_ins_valid = ($urandom_range(0, 99) < 60);
        if (s_ins_valid) begin
          s_ins = seq[DW-1:0];
          seq++;
        end
      end
      s_outs_ready = ($urandom_range(0, 99) < 50);
      #1;
      if (prev_stall) begin
        n_checks++;
        if (s_outs_valid !== 1'b1 || s_outs !== prev_outs)
          $display("FAIL rnd_stall_stable got=%b/%h exp=1/%h", s_outs_valid, s_outs, prev_outs);
        else n_pass++;
      end
      push = s_ins_valid & s_ins_ready;
      pop  = s_outs_valid & s_outs_ready;
      if (push) sb.push_back(s_ins);
      if (pop) begin
        n_checks++;
        if (sb.size() == 0) $display("FAIL rnd_dup got=%h exp=none", s_outs);
        else if (s_outs !== sb[0]) $display("FAIL rnd_order got=%h exp=%h", s_outs, sb[0]);
        else n_pass++;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      prev_stall = s_outs_valid & ~s_outs_ready;
      prev_outs  = s_outs;
      holding    = s_ins_valid & ~push;
      tick;
      n_checks++;
      if (int'(s_count) != sb.size() || s_count > 2'd3)
        $display("FAIL rnd_count got=%0d exp=%0d", s_count, sb.size());
      else n_pass++;
    end
    s_ins_valid = 1'b0; s_outs_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (s_outs_valid) begin
        n_checks++;
        if (sb.size() == 0) $display("FAIL rnd_drain_dup got=%h exp=none", s_outs);
        else if (s_outs !== sb[0]) $display("FAIL rnd_drain got=%h exp=%h", s_outs, sb[0]);
        else n_pass++;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      tick;
    end
    n_checks++; if (sb.size() != 0) $display("FAIL rnd_loss got=%0d exp=0", sb.size()); else n_pass++;
    n_checks++; if (s_count !== 2'd0) $display("FAIL rnd_final_count got=%0d exp=0", s_count); else n_pass++;
    s_outs_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_token();
    test_fill_backpressure();
    test_back_to_back();
    test_random_depth3();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
